// File: rtl/ooo_mem_pkg.sv
// Shared types and helpers for the out-of-order core's storage arrays.
// Holds the sweep state type, the write-mask expander and the default init value.
package ooo_mem_pkg;

    localparam int MAX_DW = 64;
    localparam int MAX_MW = 64;

    localparam logic [MAX_DW-1:0] INIT_VALUE_DEFAULT = '0;

    typedef enum logic [0:0] {
        INIT,
        RUN
    } ram_state_t;

    // Each wmask bit enables one contiguous slice of data_width/mask_width bits.
    // Slice 0 covers the least significant bits.
    function automatic logic [MAX_DW-1:0] expand_wmask(
        input logic [MAX_MW-1:0] wmask,
        input int                data_width,
        input int                mask_width
    );
        logic [MAX_MW-1:0] w;
        logic [MAX_DW-1:0] slice_ones;
        logic [MAX_DW-1:0] bit_mask;
        int                slice;
        slice      = data_width / mask_width;
        slice_ones = (MAX_DW'(1) << slice) - MAX_DW'(1);
        w          = wmask;
        bit_mask   = '0;
        for (int s = 0; s < MAX_MW; s++) begin
            if (s < mask_width && w[0]) begin
                bit_mask = bit_mask | (slice_ones << (s * slice));
            end
            w = w >> 1;
        end
        return bit_mask;
    endfunction

endpackage

// File: rtl/ooo_dp_ram_init_fsm.sv
// Init sweep sequencer for ooo_dp_ram: walks the array two entries per cycle,
// then grants port access by raising ready.
module ooo_dp_ram_init_fsm
    import ooo_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_req,
    output logic                  ready,
    output logic                  init_active,
    output logic [ADDR_WIDTH-1:0] sweep_addr0,
    output logic [ADDR_WIDTH-1:0] sweep_addr1
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PAIR = ADDR_WIDTH'((1 << ADDR_WIDTH) - 2);

    ram_state_t            state;
    logic [ADDR_WIDTH-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (init_req) begin
                        cnt <= '0;
                    end else if (cnt == LAST_PAIR) begin
                        state <= RUN;
                        ready <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ADDR_WIDTH'(2);
                    end
                end
                RUN: begin
                    if (init_req) begin
                        state <= INIT;
                        ready <= 1'b0;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= INIT;
                    ready <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // cnt is always even, so the pair is cnt and cnt with bit 0 set.
    assign init_active = (state == INIT);
    assign sweep_addr0 = cnt;
    assign sweep_addr1 = cnt | ADDR_WIDTH'(1);

endmodule

// File: rtl/ooo_dp_ram.sv
// Parametrised dual-port RAM with per-slice write mask, same-address collision
// merging, write-through forwarding and a hardware init sweep.
module ooo_dp_ram
    import ooo_mem_pkg::*;
#(
    parameter int                    DATA_WIDTH = 2,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    MASK_WIDTH = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = DATA_WIDTH'(INIT_VALUE_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_req,
    output logic                  ready,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [MASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    input  logic                  csb1,
    input  logic                  web1,
    input  logic [MASK_WIDTH-1:0] wmask1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] din1,
    output logic [DATA_WIDTH-1:0] dout1
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic                  init_active;
    logic [ADDR_WIDTH-1:0] sweep_addr0;
    logic [ADDR_WIDTH-1:0] sweep_addr1;

    ooo_dp_ram_init_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_req    (init_req),
        .ready       (ready),
        .init_active (init_active),
        .sweep_addr0 (sweep_addr0),
        .sweep_addr1 (sweep_addr1)
    );

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  we0, we1, re0, re1, same_addr;
    logic [DATA_WIDTH-1:0] bmask0, bmask1;
    logic [DATA_WIDTH-1:0] rd0, rd1;
    logic [DATA_WIDTH-1:0] wr0_data, wr1_data;
    logic [DATA_WIDTH-1:0] fwd0, fwd1;

    // NOTE: every always_comb output is assigned on every path, so no latch
    // can be inferred; add a default first if a branch is ever introduced.
    always_comb begin
        we0       = ready && !csb0 && !web0;
        we1       = ready && !csb1 && !web1;
        re0       = ready && !csb0 && web0;
        re1       = ready && !csb1 && web1;
        same_addr = (addr0 == addr1);
        bmask0    = DATA_WIDTH'(expand_wmask(MAX_MW'(wmask0), DATA_WIDTH, MASK_WIDTH));
        bmask1    = DATA_WIDTH'(expand_wmask(MAX_MW'(wmask1), DATA_WIDTH, MASK_WIDTH));
        rd0       = mem[addr0];
        rd1       = mem[addr1];
        wr0_data  = (rd0 & ~bmask0) | (din0 & bmask0);
        // Port 1 merges on top of port 0's slices, so it wins where both masks overlap.
        wr1_data  = (((same_addr && we0) ? wr0_data : rd1) & ~bmask1) | (din1 & bmask1);
        fwd0      = (same_addr && we1) ? wr1_data : rd0;
        fwd1      = (same_addr && we0) ? wr0_data : rd1;
    end

    // NOTE: the array has no reset so it can map onto a RAM macro; the init
    // sweep is what gives it defined contents.
    always_ff @(posedge clk) begin
        if (init_active) begin
            mem[sweep_addr0] <= INIT_VALUE;
            mem[sweep_addr1] <= INIT_VALUE;
        end else begin
            if (we0 && !(same_addr && we1)) begin
                mem[addr0] <= wr0_data;
            end
            if (we1) begin
                mem[addr1] <= wr1_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout0 <= '0;
            dout1 <= '0;
        end else begin
            if (re0) begin
                dout0 <= fwd0;
            end
            if (re1) begin
                dout1 <= fwd1;
            end
        end
    end

endmodule

// File: tb/tb_ooo_dp_ram.sv
// Scoreboard bench for ooo_dp_ram (8-bit entries, two 4-bit mask slices,
// init value 8'h5A): directed vectors with hand-computed read data.
module tb_ooo_dp_ram;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       init_req;
    logic       ready;
    logic       csb0, web0, csb1, web1;
    logic [1:0] wmask0, wmask1;
    logic [7:0] addr0, addr1, din0, din1;
    logic [7:0] dout0, dout1;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [7:0] val;
        string      name;
    } sb_t;

    sb_t exp0[$];
    sb_t exp1[$];

    ooo_dp_ram #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (8),
        .MASK_WIDTH (2),
        .INIT_VALUE (8'h5A)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .init_req (init_req),
        .ready    (ready),
        .csb0     (csb0),
        .web0     (web0),
        .wmask0   (wmask0),
        .addr0    (addr0),
        .din0     (din0),
        .dout0    (dout0),
        .csb1     (csb1),
        .web1     (web1),
        .wmask1   (wmask1),
        .addr1    (addr1),
        .din1     (din1),
        .dout1    (dout1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        csb0     = 1'b1;
        csb1     = 1'b1;
        web0     = 1'b1;
        web1     = 1'b1;
        init_req = 1'b0;
    endtask

    task automatic rd(input int port, input logic [7:0] a, input logic [7:0] e, input string name);
        sb_t item;
        item.val  = e;
        item.name = name;
        if (port == 0) begin
            csb0 = 1'b0; web0 = 1'b1; addr0 = a;
            exp0.push_back(item);
        end else begin
            csb1 = 1'b0; web1 = 1'b1; addr1 = a;
            exp1.push_back(item);
        end
    endtask

    task automatic wr(input int port, input logic [7:0] a, input logic [7:0] d, input logic [1:0] m);
        if (port == 0) begin
            csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
        end else begin
            csb1 = 1'b0; web1 = 1'b0; addr1 = a; din1 = d; wmask1 = m;
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
    endtask

    // Monitor: a read accepted at a rising edge presents dout by the next falling edge.
    initial begin : monitor
        bit  f0, f1;
        sb_t e;
        forever begin
            @(posedge clk);
            f0 = rst_n && ready && !csb0 && web0;
            f1 = rst_n && ready && !csb1 && web1;
            @(negedge clk);
            if (f0) begin
                if (exp0.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL sb0_unexpected: got read data %0h, expected no read", dout0);
                end else begin
                    e = exp0.pop_front();
                    check(e.name, 32'(dout0), 32'(e.val));
                end
            end
            if (f1) begin
                if (exp1.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL sb1_unexpected: got read data %0h, expected no read", dout1);
                end else begin
                    e = exp1.pop_front();
                    check(e.name, 32'(dout1), 32'(e.val));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int n;
        rst_n = 1'b0; init_req = 1'b0;
        csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
        csb1 = 1'b1; web1 = 1'b1; wmask1 = '0; addr1 = '0; din1 = '0;
        #3;
        check("rst_ready", 32'(ready), 0);
        check("rst_dout0", 32'(dout0), 0);
        check("rst_dout1", 32'(dout1), 0);
        repeat (3) step();
        rst_n = 1'b1;
        wait_ready(n);
        check("init_cycles", n, 128);

        // Sweep contents at both ends and the middle.
        rd(0, 8'd0, 8'h5A, "init_addr0"); rd(1, 8'd127, 8'h5A, "init_addr127"); step();
        rd(0, 8'd255, 8'h5A, "init_addr255"); step();

        // Masked writes: upper slice only, then lower slice only.
        wr(0, 8'd5, 8'hAB, 2'b10); step();
        rd(1, 8'd5, 8'hAA, "mask_hi"); wr(0, 8'd6, 8'hCD, 2'b01); step();
        rd(0, 8'd6, 8'h5D, "mask_lo"); step();

        // Write/write collisions: full overlap, partial overlap, disjoint slices.
        wr(0, 8'd9, 8'h12, 2'b11);  wr(1, 8'd9, 8'h34, 2'b11);  step();
        wr(0, 8'd10, 8'h12, 2'b11); wr(1, 8'd10, 8'h34, 2'b10); step();
        wr(0, 8'd11, 8'h12, 2'b10); wr(1, 8'd11, 8'h34, 2'b01); step();
        rd(0, 8'd9, 8'h34, "ww_full"); rd(1, 8'd10, 8'h32, "ww_partial"); step();
        rd(0, 8'd11, 8'h14, "ww_disjoint"); step();

        // Read/write collisions forward the merged word; the writer's dout holds.
        wr(0, 8'd3, 8'hC7, 2'b01); rd(1, 8'd3, 8'h57, "rw_fwd1"); step();
        check("wr_hold0", 32'(dout0), 32'h14);
        wr(1, 8'd4, 8'hE9, 2'b11); rd(0, 8'd4, 8'hE9, "rw_fwd0"); step();
        check("wr_hold1", 32'(dout1), 32'h57);
        repeat (3) step();
        check("idle_hold0", 32'(dout0), 32'hE9);
        check("idle_hold1", 32'(dout1), 32'h57);

        // init_req mid-operation; requests during the sweep are ignored.
        wr(0, 8'd0, 8'hFF, 2'b11); step();
        rd(1, 8'd0, 8'hFF, "pre_init_wr"); step();
        init_req = 1'b1; step();
        check("init_req_ready_drop", 32'(ready), 0);
        csb0 = 1'b0; web0 = 1'b0; addr0 = 8'd200; din0 = 8'h00; wmask0 = 2'b11;
        csb1 = 1'b0; web1 = 1'b1; addr1 = 8'd0;
        wait_ready(n);
        check("reinit_cycles", n, 128);
        check("init_ignored_rd", 32'(dout1), 32'hFF);
        rd(0, 8'd0, 8'h5A, "reinit_addr0"); rd(1, 8'd200, 8'h5A, "init_ignored_wr"); step();

        // init_req during the sweep restarts it from entry 0.
        init_req = 1'b1; step();
        repeat (9) step();
        init_req = 1'b1;
        wait_ready(n);
        check("restart_cycles", n, 129);

        // Asynchronous reset 40 cycles into a sweep.
        init_req = 1'b1; step();
        repeat (40) step();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ready", 32'(ready), 0);
        check("async_rst_dout0", 32'(dout0), 0);
        check("async_rst_dout1", 32'(dout1), 0);
        step();
        rst_n = 1'b1;
        wait_ready(n);
        check("rst_sweep_cycles", n, 128);
        rd(0, 8'd5, 8'h5A, "post_rst_addr5"); rd(1, 8'd9, 8'h5A, "post_rst_addr9"); step();

        repeat (3) step();
        check("sb_drain", exp0.size() + exp1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
